// File: rtl/hsca_sel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hsca_sel_pkg : shared selection-mode type for the operand selector     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hsca_sel_pkg;

  typedef enum logic {
    SEL_FIXED = 1'b0,
    SEL_RR    = 1'b1
  } sel_mode_e;

endpackage
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | skid_buf2 : 2-entry valid/ready skid buffer, in_ready from state only |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module skid_buf2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [DW-1:0] skid_data;
  logic          skid_valid;
  logic          accept;
  logic          main_free;

  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign main_free = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (main_free) begin
      if (skid_valid) begin
        // Skid drains first so words leave in acceptance order.
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= accept;
        if (accept) begin
          skid_data <= in_data;
        end
      end else begin
        out_valid <= accept;
        if (accept) begin
          out_data <= in_data;
        end
      end
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/operand_sel_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | operand_sel_pipe : NCH-channel operand selector, fixed/round-robin    |
// |                    grant, registered flow-controlled output          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module operand_sel_pipe
  import hsca_sel_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  sel_mode_e            mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]       rr_ptr;
  logic [SELW-1:0]       rr_next;
  logic [SELW-1:0]       grant;
  logic                  grant_valid;
  logic                  grant_in_valid;
  logic [WIDTH-1:0]      grant_data;
  logic [SELW:0]         scan_idx;
  logic [SELW:0]         grant_inc;
  logic                  can_acc;
  logic                  accept;
  logic [WIDTH+SELW-1:0] buf_out;

  always_comb begin : grant_scan
    grant_valid = 1'b0;
    grant       = '0;
    scan_idx    = '0;
    if (mode == SEL_FIXED) begin
      // Only indexes that name a real channel produce a grant.
      for (int k = 0; k < NCH; k++) begin
        if (sel == SELW'(k)) begin
          grant_valid = 1'b1;
        end
      end
      grant = sel;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        scan_idx = {1'b0, rr_ptr} + (SELW+1)'(i);
        if (scan_idx >= (SELW+1)'(NCH)) begin
          scan_idx = scan_idx - (SELW+1)'(NCH);
        end
        if (!grant_valid && in_valid[scan_idx[SELW-1:0]]) begin
          grant_valid = 1'b1;
          grant       = scan_idx[SELW-1:0];
        end
      end
    end
  end

  always_comb begin : grant_mux
    grant_in_valid = 1'b0;
    grant_data     = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant == SELW'(k)) begin
        grant_in_valid = in_valid[k];
        grant_data     = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : ready_decode
    in_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant_valid && (grant == SELW'(k))) begin
        in_ready[k] = can_acc & ~reset;
      end
    end
  end

  assign accept    = grant_valid & grant_in_valid & can_acc;
  assign grant_inc = {1'b0, grant} + (SELW+1)'(1);
  assign rr_next   = (grant_inc >= (SELW+1)'(NCH)) ? '0 : grant_inc[SELW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept && (mode == SEL_RR)) begin
      rr_ptr <= rr_next;
    end
  end

  skid_buf2 #(
    .DW(WIDTH + SELW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_data   ({grant_data, grant}),
    .in_valid  (grant_valid & grant_in_valid),
    .in_ready  (can_acc),
    .out_data  (buf_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign {out_data, out_ch} = buf_out;

endmodule
`default_nettype wire

// File: tb/tb_operand_sel_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_operand_sel_pipe : scoreboard bench with a queue-based ref model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_operand_sel_pipe;
  import hsca_sel_pkg::*;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk;
  logic           reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  sel_mode_e      mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  sel_mode_e      mode3;
  logic [1:0]     sel3;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_ch3;
  logic           out_valid3;
  logic           out_ready3;

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] ch;
  } item_t;

  item_t        exp_q[$];
  logic [W-1:0] data_log[$];
  int           ch_log[$];
  int           occ;
  int           rr;
  int           errors;
  int           checks;
  int           mg;
  logic [N-1:0] exp_ir;
  bit           macc;

  operand_sel_pipe #(.WIDTH(W), .NCH(N)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  operand_sel_pipe #(.WIDTH(W), .NCH(3)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference grant: first requesting channel at or after the pointer, or the fixed index.
  function automatic int ref_grant(input sel_mode_e m, input int s, input logic [N-1:0] v, input int r);
    if (m == SEL_FIXED) return (s < N) ? s : -1;
    for (int i = 0; i < N; i++) begin
      if (v[(r + i) % N]) return (r + i) % N;
    end
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = '0;
    repeat (2) next_cycle();
    reset = 1'b0;
    data_log.delete();
    ch_log.delete();
  endtask

  // Monitor: compares the presented word against the head of the expectation queue.
  always @(negedge clk) begin
    if (!reset) begin
      check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
      if (out_valid && exp_q.size() > 0) begin
        check("out_data", {48'd0, out_data}, {48'd0, exp_q[0].d});
        check("out_ch", {62'd0, out_ch}, {62'd0, exp_q[0].ch});
        if (out_ready) begin
          data_log.push_back(out_data);
          ch_log.push_back(int'(out_ch));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Model: two-deep output store, predicts ready and pushes accepted payloads.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      exp_q.delete();
      occ = 0;
      rr  = 0;
      check("in_ready_rst", {60'd0, in_ready}, 64'd0);
    end else begin
      mg     = ref_grant(mode, int'(sel), in_valid, rr);
      exp_ir = (mg >= 0 && occ < 2) ? (N'(1) << mg) : '0;
      check("in_ready", {60'd0, in_ready}, {60'd0, exp_ir});
      macc = (mg >= 0) && in_valid[mg] && (occ < 2);
      if (occ > 0 && out_ready) occ--;
      if (macc) begin
        occ++;
        exp_q.push_back('{in_data[mg*W +: W], SW'(mg)});
        if (mode == SEL_RR) rr = (mg + 1) % N;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] wa, wb, wc;
    errors = 0;
    checks = 0;
    reset     = 1'b1;
    in_valid  = '1;
    in_data   = {$urandom, $urandom};
    mode      = SEL_RR;
    sel       = '0;
    out_ready = 1'b1;
    in_data3  = '0;
    in_valid3 = 3'b111;
    mode3     = SEL_FIXED;
    sel3      = 2'd3;
    out_ready3 = 1'b1;
    repeat (2) next_cycle();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {48'd0, out_data}, 64'd0);
    check("rst_out_ch", {62'd0, out_ch}, 64'd0);
    check("rst_in_ready", {60'd0, in_ready}, 64'd0);
    reset = 1'b0;

    // Fixed select of channel 2.
    mode = SEL_FIXED;
    sel  = 2'd2;
    in_data[2*W +: W] = 16'hBEEF;
    #1;
    check("t1_in_ready", {60'd0, in_ready}, 64'h4);
    next_cycle();
    check("t1_out_valid", {63'd0, out_valid}, 64'd1);
    check("t1_out_data", {48'd0, out_data}, 64'hBEEF);
    check("t1_out_ch", {62'd0, out_ch}, 64'd2);
    in_valid = '0;
    repeat (4) next_cycle();

    // Round-robin with all channels requesting.
    apply_reset();
    mode = SEL_RR;
    in_valid = 4'hF;
    repeat (6) begin
      in_data = {$urandom, $urandom};
      next_cycle();
    end
    in_valid = '0;
    repeat (4) next_cycle();
    check("t2_count", 64'(ch_log.size() >= 5), 64'd1);
    if (ch_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("t2_rr_ch", 64'(ch_log[i]), 64'(i % 4));
    end

    // Sparse round-robin: only channels 1 and 3 request.
    apply_reset();
    mode = SEL_RR;
    in_valid = 4'b1010;
    repeat (6) next_cycle();
    in_valid = '0;
    repeat (4) next_cycle();
    check("t3_count", 64'(ch_log.size() >= 4), 64'd1);
    if (ch_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("t3_rr_ch", 64'(ch_log[i]), (i % 2 == 0) ? 64'd1 : 64'd3);
    end

    // Backpressure: A and B buffered, C held off until space frees.
    apply_reset();
    mode = SEL_FIXED;
    sel = 2'd1;
    out_ready = 1'b0;
    wa = 16'hA0A1; wb = 16'hB0B2; wc = 16'hC0C3;
    in_valid = 4'b0010;
    in_data[W +: W] = wa;
    #1 check("t4_ready_a", {60'd0, in_ready}, 64'h2);
    next_cycle();
    in_data[W +: W] = wb;
    #1 check("t4_ready_b", {60'd0, in_ready}, 64'h2);
    next_cycle();
    in_data[W +: W] = wc;
    #1 check("t4_ready_full", {60'd0, in_ready}, 64'h0);
    repeat (3) next_cycle();
    check("t4_still_full", {60'd0, in_ready}, 64'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && !in_ready[1]; i++) next_cycle();
    next_cycle();
    in_valid = '0;
    repeat (4) next_cycle();
    check("t4_count", 64'(data_log.size()), 64'd3);
    if (data_log.size() == 3) begin
      check("t4_word_a", {48'd0, data_log[0]}, {48'd0, wa});
      check("t4_word_b", {48'd0, data_log[1]}, {48'd0, wb});
      check("t4_word_c", {48'd0, data_log[2]}, {48'd0, wc});
    end

    // Reset between edges with two words buffered.
    apply_reset();
    mode = SEL_FIXED;
    sel = 2'd0;
    out_ready = 1'b0;
    in_valid = 4'b0001;
    repeat (2) next_cycle();
    in_valid = '0;
    next_cycle();
    check("t5_buffered", {63'd0, out_valid}, 64'd1);
    #3;
    reset = 1'b1;
    #1;
    check("t5_rst_valid", {63'd0, out_valid}, 64'd0);
    check("t5_rst_ready", {60'd0, in_ready}, 64'd0);
    mode = SEL_RR;
    in_valid = 4'hF;
    out_ready = 1'b1;
    next_cycle();
    data_log.delete();
    ch_log.delete();
    reset = 1'b0;
    repeat (2) next_cycle();
    in_valid = '0;
    repeat (4) next_cycle();
    check("t5_count", 64'(ch_log.size() > 0), 64'd1);
    if (ch_log.size() > 0) check("t5_first_ch", 64'(ch_log[0]), 64'd0);

    // Three channels: an out-of-range select never grants.
    for (int i = 0; i < 10; i++) begin
      check("t6_in_ready", {61'd0, in_ready3}, 64'd0);
      check("t6_out_valid", {63'd0, out_valid3}, 64'd0);
      next_cycle();
    end
    sel3 = 2'd2;
    in_data3[2*W +: W] = 16'h1234;
    #1 check("t6_sel2_ready", {61'd0, in_ready3}, 64'h4);
    next_cycle();
    check("t6_sel2_valid", {63'd0, out_valid3}, 64'd1);
    check("t6_sel2_data", {48'd0, out_data3}, 64'h1234);
    check("t6_sel2_ch", {62'd0, out_ch3}, 64'd2);
    in_valid3 = '0;

    // Randomized traffic with mode/select changes and backpressure.
    for (int i = 0; i < 1500; i++) begin
      in_data  = {$urandom, $urandom};
      in_valid = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = sel_mode_e'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) sel = SW'($urandom_range(0, N - 1));
      next_cycle();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (5) next_cycle();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
